// File: rtl/fir_output_packer_pkg.sv
// ============================================================================
// Module : fir_pkg
// Brief  : Shared defaults, saturation limits and serializer state encoding
//          for the FIR output packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int IN_WIDTH_DEF  = 38;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int OUT_MAX       = 32767;
  localparam int OUT_MIN       = -32768;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/fir_output_packer_sample_fifo.sv
// ============================================================================
// Module : sample_fifo
// Brief  : Synchronous FIFO for scaled samples; DEPTH must be a power of two
//          so the pointers wrap naturally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_output_packer.sv
// ============================================================================
// Module : fir_output_packer
// Brief  : Scales/saturates FIR accumulator results to 16 bits, buffers them
//          and serializes each as low byte then high byte to a UART.
//          Build option: FIR_OUTPUT_ROUND_EN selects round-half-up scaling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_output_packer
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [IN_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic        [7:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       sat_flag,
  output logic                       busy
);

  localparam logic signed [IN_WIDTH:0]  SAT_HI = (IN_WIDTH + 1)'(OUT_MAX);
  localparam logic signed [IN_WIDTH:0]  SAT_LO = (IN_WIDTH + 1)'(OUT_MIN);
  localparam logic        [OUT_WIDTH-1:0] OUT_MAX_V = OUT_WIDTH'(OUT_MAX);
  localparam logic        [OUT_WIDTH-1:0] OUT_MIN_V = OUT_WIDTH'(OUT_MIN);

  logic signed [IN_WIDTH:0]  w_ext;
  logic signed [IN_WIDTH:0]  w_pre;
  logic signed [IN_WIDTH:0]  w_shr;
  logic                      w_sat_hi;
  logic                      w_sat_lo;
  logic        [OUT_WIDTH-1:0] w_scaled;
  logic                      w_accept;

  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_pop;
  logic        [OUT_WIDTH-1:0] w_fifo_rdata;

  ser_state_e                state_q, state_d;
  logic        [OUT_WIDTH-1:0] hold_q, hold_d;
  logic                      sat_q, sat_d;

  // One extra bit of headroom keeps the rounding add from overflowing.
  assign w_ext = {in_data[IN_WIDTH-1], in_data};

`ifdef FIR_OUTPUT_ROUND_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_WIDTH:0] ROUND_ADD =
    (SHIFT > 0) ? ((IN_WIDTH + 1)'(1) << RSH) : '0;
  assign w_pre = w_ext + ROUND_ADD;
`else
  assign w_pre = w_ext;
`endif

  assign w_shr    = w_pre >>> SHIFT;
  assign w_sat_hi = (w_shr > SAT_HI);
  assign w_sat_lo = (w_shr < SAT_LO);
  assign w_scaled = w_sat_hi ? OUT_MAX_V :
                    w_sat_lo ? OUT_MIN_V : w_shr[OUT_WIDTH-1:0];

  assign in_ready = !w_fifo_full;
  assign w_accept = in_valid && in_ready;
  assign sat_d    = sat_q | (w_accept & (w_sat_hi | w_sat_lo));
  assign sat_flag = sat_q;
  assign busy     = !w_fifo_empty || (state_q != ST_IDLE);

  sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_accept),
    .wdata_i (w_scaled),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sat_q   <= sat_d;
    end
  end

  // The high-byte handshake reloads directly so back-to-back samples never idle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    w_pop    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop   = 1'b1;
          hold_d  = w_fifo_rdata;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = hold_q[7:0];
        if (tx_ready) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = hold_q[15:8];
        if (tx_ready) begin
          if (!w_fifo_empty) begin
            w_pop   = 1'b1;
            hold_d  = w_fifo_rdata;
            state_d = ST_SEND_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
